// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory/I-O bridge.
// The boot image exists only when MEM_INIT_EN is defined.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [15:0] MMIO_IO_ADDR = 16'hFFFF;

`ifdef MEM_INIT_EN
  localparam int INIT_IMG_LEN = 64;
  typedef logic [INIT_IMG_LEN-1:0][15:0] init_img_t;

  // Boot image: a recognisable ramp, one word per address.
  function automatic init_img_t gen_init_img();
    init_img_t img;
    for (int i = 0; i < INIT_IMG_LEN; i++) img[i] = 16'h5000 | 16'(i * 7);
    return img;
  endfunction

  localparam init_img_t INIT_IMAGE = gen_init_img();
`endif

endpackage

// File: rtl/slc3_mem_bridge_if.sv
// CPU-side memory request/response bus of the SLC-3 memory bridge.
interface slc3_mem_bridge_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_mem_ena;
  logic        mem_wr_ena;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/slc3_mem_bridge_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/slc3_mem_bridge.sv
// SLC-3 memory/I-O bridge: BRAM access with read-latency hiding, MMIO at 0xFFFF.
// Define MEM_INIT_EN to preload the boot image into BRAM after reset.
module slc3_mem_bridge
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 2,
  parameter int INIT_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  slc3_mem_bridge_if.slave  bus,
  output logic              init_done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [15:0]       bram_wdata,
  output logic              bram_en,
  output logic              bram_we,
  input  logic [15:0]       bram_rdata,
  input  logic [15:0]       sw_i,
  output logic [15:0]       hex_o
);

`ifdef MEM_INIT_EN
  localparam state_e RST_STATE = ST_INIT;
  localparam int     IDX_W     = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
  logic [IDX_W-1:0] init_idx;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e      state, nxt;
  logic [15:0] lat_addr, lat_wdata, rdata_q, sw_sync;
  logic        lat_we, ready, is_mmio, is_bram, last_beat;
  logic [1:0]  wait_cnt;

  sync_2ff #(.WIDTH(16)) u_sw_sync (.clk(clk), .reset(reset), .d(sw_i), .q(sw_sync));

  // Decode on the latched address; MMIO wins if ADDR_W spans the full space.
  assign is_mmio   = (lat_addr == MMIO_IO_ADDR);
  assign is_bram   = !is_mmio && ((32'(lat_addr) >> ADDR_W) == 32'd0);
  assign last_beat = (wait_cnt == 2'(RD_LAT - 2));

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready;

  always_ff @(posedge clk) begin
    if (reset) state <= RST_STATE;
    else       state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= '0;
      hex_o     <= '0;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
`ifdef MEM_INIT_EN
      init_idx  <= '0;
`endif
    end else begin
      case (state)
`ifdef MEM_INIT_EN
        ST_INIT: init_idx <= init_idx + 1'b1;
`endif
        ST_IDLE: if (bus.mem_mem_ena) begin
          lat_addr  <= bus.mem_addr;
          lat_wdata <= bus.mem_wdata;
          lat_we    <= bus.mem_wr_ena;
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          if (lat_we) begin
            if (is_mmio) hex_o <= lat_wdata;
          end else if (is_mmio)   rdata_q <= sw_sync;
          else if (!is_bram)      rdata_q <= '0;
          else if (RD_LAT == 1)   rdata_q <= bram_rdata;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (last_beat) rdata_q <= bram_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
`ifdef MEM_INIT_EN
      ST_INIT:  if (init_idx == IDX_W'(INIT_WORDS - 1)) nxt = ST_IDLE;
`else
      ST_INIT:  nxt = ST_IDLE;
`endif
      ST_IDLE:  if (bus.mem_mem_ena) nxt = ST_ISSUE;
      ST_ISSUE: nxt = (!lat_we && is_bram && RD_LAT > 1) ? ST_WAIT : ST_DONE;
      ST_WAIT:  if (last_beat) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = RST_STATE;
    endcase
  end

  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = lat_addr[ADDR_W-1:0];
    bram_wdata = lat_wdata;
    ready      = 1'b0;
    case (state)
`ifdef MEM_INIT_EN
      ST_INIT: begin
        // Held off while reset is asserted so a restart never leaves a stray write.
        bram_en    = !reset;
        bram_we    = !reset;
        bram_addr  = ADDR_W'(init_idx);
        bram_wdata = INIT_IMAGE[init_idx];
      end
`endif
      ST_ISSUE: if (is_bram) begin
        bram_en = 1'b1;
        bram_we = lat_we;
      end
      ST_DONE: ready = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_INIT_EN
  assign init_done = (state != ST_INIT);
`else
  assign init_done = 1'b1;
`endif

endmodule

// File: doc/slc3_mem_bridge.md
# slc3_mem_bridge

Memory/I-O bridge sitting directly downstream of the SLC-3 CPU core. It consumes the CPU's memory request (address, write data, enable, write-enable) and returns read data with an explicit ready pulse. It hides the on-chip BRAM's multi-cycle read latency and decodes memory-mapped I/O at 0xFFFF: reads return the switches, writes update the hex display. Optionally it preloads a program image into BRAM after reset.

## Interface
- ADDR_W, 10: BRAM address width; mapped BRAM range is 0 to 2^ADDR_W-1.
- RD_LAT, 2: BRAM read latency in cycles (bram_en to valid bram_rdata); legal 1–4.
- INIT_WORDS, 64: image length written by the init loader.

Ports:
- clk  in  1  system clock; one clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- mem_addr  in  16  CPU request address.
- mem_wdata  in  16  CPU write data.
- mem_mem_ena  in  1  CPU request valid.
- mem_wr_ena  in  1  1 = write, 0 = read; qualified by mem_mem_ena.
- mem_rdata  out  16  read data, registered.
- mem_ready  out  1  one-cycle completion pulse.
- init_done  out  1  high once the bridge accepts requests.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  16  BRAM write data.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_rdata  in  16  BRAM read data.
- sw_i  in  16  board switches, asynchronous.
- hex_o  out  16  hex display register.

## Operation
- States: INIT, IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If mem_mem_ena=1, latch address, data and direction, then go to ISSUE.
  - Otherwise remain in IDLE.
- Address decode is performed on the latched address:
  - 0xFFFF: MMIO.
  - Below 2^ADDR_W: BRAM.
  - Anything else: unmapped.
- ISSUE:
  - BRAM read: bram_en=1, then go to WAIT.
  - BRAM write: bram_en=1 and bram_we=1 for exactly this cycle, then go to DONE.
  - MMIO read: capture the synchronized switches into mem_rdata, then go to DONE.
  - MMIO write: hex_o <= latched data, then go to DONE.
  - Unmapped read: mem_rdata <= 0x0000. Unmapped write: dropped, bram_we stays 0. Both go to DONE.
- WAIT:
  - Count RD_LAT-1 further cycles.
  - Capture bram_rdata into mem_rdata on the last count, then go to DONE.
- DONE:
  - mem_ready=1 for this single cycle.
  - mem_mem_ena is ignored.
  - Next state is IDLE.
- mem_rdata holds its value until the next read completes. Writes do not change it.
- The CPU must hold its request stable until it sees mem_ready. It must drop or change the request by the cycle after DONE, because IDLE re-samples mem_mem_ena.
- sw_i always passes through a 2-flop synchronizer.
- hex_o changes only on MMIO writes.

## Timing
- Request sampled in IDLE at cycle T.
- BRAM read: bram_en at T+1, mem_ready and valid mem_rdata at T+1+RD_LAT (T+3 by default).
- BRAM write, MMIO access, unmapped access: mem_ready at T+2.
- MMIO write: hex_o updates at T+2.
- Reset (any state, any cycle), effective at the next edge:
  - Outputs: mem_ready=0, mem_rdata=0, hex_o=0, bram_en=0, bram_we=0.
  - State: INIT if MEM_INIT_EN is defined, otherwise IDLE.
  - No ready pulse is emitted for an aborted request.
  - A BRAM write is either fully issued (its ISSUE cycle already passed) or never issued.
- Back-to-back requests: minimum spacing is 1 + (completion latency) + 1 cycles.

## Configuration
- MEM_INIT_EN defined:
  - After reset, the INIT state writes image word i to BRAM address i, one word per cycle, for i = 0..INIT_WORDS-1 (bram_en=bram_we=1).
  - init_done=0 throughout INIT. mem_mem_ena is ignored and mem_ready stays 0.
  - Then go to IDLE with init_done=1.
  - A reset during INIT restarts at i=0.
- MEM_INIT_EN undefined:
  - No INIT state and no image.
  - init_done=1 from the first cycle after reset.

## Structure
- Package slc3_mem_pkg:
  - State enum.
  - MMIO_IO_ADDR = 16'hFFFF.
  - Init image constant array, INIT_WORDS × 16 bits, present only under MEM_INIT_EN.
- Sub-module sync_2ff (parameterized width) for sw_i.
- All else in slc3_mem_bridge.

## Test plan
- BRAM[0x0005]=0x1234; read 0x0005 at T → bram_en at T+1, mem_ready pulse at T+3, mem_rdata=0x1234.
- Write 0xBEEF to 0x0010 at T → bram_we=1 only at T+1 with bram_addr=0x010, mem_ready at T+2; a follow-up read returns 0xBEEF.
- sw_i=0x00A5 held ≥2 cycles; read 0xFFFF → mem_ready at T+2, mem_rdata=0x00A5. Write 0x3C3C to 0xFFFF → hex_o=0x3C3C at T+2, BRAM untouched.
- Read 0x8000 → mem_rdata=0x0000, mem_ready at T+2. Write 0x8000 → bram_we never asserted, mem_ready at T+2.
- BRAM read started at T, reset asserted at T+2 → from T+3: mem_ready=0 with no pulse, mem_rdata=0, state IDLE (or INIT).
- MEM_INIT_EN defined:
  - init_done=0 for 64 cycles after reset; afterwards BRAM[63] equals image[63].
  - A request issued during INIT is ignored and produces no mem_ready.
